// File: rtl/cps1_sync_lock_ctrl_pkg.sv
// Shared encodings and timing defaults for the CPS1 sync-lock supervisor.
// The cfg ID width tracks the entries of mclk_cfg_ids.vh.
package cps1_sync_lock_ctrl_pkg;

    localparam int CFG_ID_W          = 5;
    localparam int PCLK_W            = 11;
    localparam int LINE_W            = 10;
    localparam int WDOG_W            = 20;

    localparam int H_NOM_DEF         = 1024;
    localparam int H_TOL_DEF         = 4;
    localparam int V_NOM_DEF         = 262;
    localparam int V_TOL_DEF         = 2;
    localparam int LOCK_FRAMES_DEF   = 4;
    localparam int UNLOCK_FRAMES_DEF = 2;
    localparam int TIMEOUT_DEF       = 1048576;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_CFG_REQ  = 2'd1,
        ST_LOCKED   = 2'd2,
        ST_ILLEGAL  = 2'd3
    } lock_state_e;

    function automatic logic in_window(input int val, input int nom, input int tol);
        return (val >= nom - tol) && (val <= nom + tol);
    endfunction

endpackage

// File: rtl/cps1_sync_meter.sv
// Measures line length and lines per frame from HSYNC/frame_change, runs the
// frame watchdog and emits one registered good/bad verdict per frame.
module cps1_sync_meter
    import cps1_sync_lock_ctrl_pkg::*;
#(
    parameter int H_NOM   = H_NOM_DEF,
    parameter int H_TOL   = H_TOL_DEF,
    parameter int V_NOM   = V_NOM_DEF,
    parameter int V_TOL   = V_TOL_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              hsync_i,
    input  logic              frame_change_i,
    output logic              frame_valid_o,
    output logic              frame_good_o,
    output logic [PCLK_W-1:0] line_pclks_o,
    output logic [LINE_W-1:0] frame_lines_o
);

    localparam logic [PCLK_W-1:0] PCLK_MAX  = '1;
    localparam logic [LINE_W-1:0] LINE_MAX  = '1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

    logic              hsync_q, fc_q;
    logic [PCLK_W-1:0] pclk_ctr_q, line_pclks_q;
    logic [LINE_W-1:0] line_ctr_q, frame_lines_q;
    logic              line_err_q;
    logic [WDOG_W-1:0] wdog_q;
    logic              vld_q, good_q;

    logic              hs_ev, bnd, wd_fire, line_ok, frame_ok;
    logic [PCLK_W-1:0] line_len;

    assign hs_ev    = hsync_q & ~hsync_i;
    assign bnd      = frame_change_i & ~fc_q;
    assign wd_fire  = (wdog_q == WDOG_LAST);
    assign line_len = (pclk_ctr_q == PCLK_MAX) ? PCLK_MAX : pclk_ctr_q + PCLK_W'(1);
    assign line_ok  = in_window(int'(line_len), H_NOM, H_TOL);
    // A bad line ending on the boundary cycle still belongs to the closing frame.
    assign frame_ok = in_window(int'(line_ctr_q), V_NOM, V_TOL) && !line_err_q
                      && !(hs_ev && !line_ok);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hsync_q       <= 1'b0;
            fc_q          <= 1'b0;
            pclk_ctr_q    <= '0;
            line_pclks_q  <= '0;
            line_ctr_q    <= '0;
            frame_lines_q <= '0;
            line_err_q    <= 1'b0;
            wdog_q        <= '0;
            vld_q         <= 1'b0;
            good_q        <= 1'b0;
        end else begin
            hsync_q <= hsync_i;
            fc_q    <= frame_change_i;

            if (hs_ev) begin
                line_pclks_q <= line_len;
                pclk_ctr_q   <= '0;
            end else if (pclk_ctr_q != PCLK_MAX) begin
                pclk_ctr_q <= pclk_ctr_q + PCLK_W'(1);
            end

            if (bnd) begin
                frame_lines_q <= line_ctr_q;
                line_ctr_q    <= hs_ev ? LINE_W'(1) : '0;
                line_err_q    <= 1'b0;
            end else if (hs_ev) begin
                if (line_ctr_q != LINE_MAX)
                    line_ctr_q <= line_ctr_q + LINE_W'(1);
                if (!line_ok)
                    line_err_q <= 1'b1;
            end

            // Boundary takes precedence over a coincident watchdog expiry.
            wdog_q <= (bnd || wd_fire) ? '0 : wdog_q + WDOG_W'(1);
            vld_q  <= bnd | wd_fire;
            good_q <= bnd & frame_ok;
        end
    end

    assign frame_valid_o = vld_q;
    assign frame_good_o  = good_q;
    assign line_pclks_o  = line_pclks_q;
    assign frame_lines_o = frame_lines_q;

endmodule

// File: rtl/cps1_sync_lock_ctrl.sv
// Lock FSM with hysteresis over the meter's frame verdicts, plus the MCLK
// reconfiguration request/ack handshake that gates downstream video.
module cps1_sync_lock_ctrl
    import cps1_sync_lock_ctrl_pkg::*;
#(
    parameter int H_NOM         = H_NOM_DEF,
    parameter int H_TOL         = H_TOL_DEF,
    parameter int V_NOM         = V_NOM_DEF,
    parameter int V_TOL         = V_TOL_DEF,
    parameter int LOCK_FRAMES   = LOCK_FRAMES_DEF,
    parameter int UNLOCK_FRAMES = UNLOCK_FRAMES_DEF,
    parameter int TIMEOUT       = TIMEOUT_DEF
) (
    input  logic                PCLK_i,
    input  logic                RESET_i,
    input  logic                HSYNC_i,
    input  logic                frame_change_i,
    input  logic [CFG_ID_W-1:0] mclk_cfg_id_i,
    input  logic                cfg_ack_i,
    output logic                cfg_req_o,
    output logic [CFG_ID_W-1:0] cfg_id_o,
    output logic                out_en_o,
    output logic                locked_o,
    output logic [1:0]          state_o,
    output logic [PCLK_W-1:0]   line_pclks_o,
    output logic [LINE_W-1:0]   frame_lines_o
);

    localparam logic [7:0] LOCK_LAST   = 8'(LOCK_FRAMES - 1);
    localparam logic [7:0] UNLOCK_LAST = 8'(UNLOCK_FRAMES - 1);

    logic frame_valid, frame_good, frame_bad;

    cps1_sync_meter #(
        .H_NOM  (H_NOM),
        .H_TOL  (H_TOL),
        .V_NOM  (V_NOM),
        .V_TOL  (V_TOL),
        .TIMEOUT(TIMEOUT)
    ) u_meter (
        .clk_i         (PCLK_i),
        .rst_i         (RESET_i),
        .hsync_i       (HSYNC_i),
        .frame_change_i(frame_change_i),
        .frame_valid_o (frame_valid),
        .frame_good_o  (frame_good),
        .line_pclks_o  (line_pclks_o),
        .frame_lines_o (frame_lines_o)
    );

    assign frame_bad = frame_valid & ~frame_good;

    lock_state_e         state_q;
    logic [7:0]          good_cnt_q, bad_cnt_q;
    logic                pend_bad_q, cfg_req_q, out_en_q, locked_q;
    logic [CFG_ID_W-1:0] cfg_id_q;

    always_ff @(posedge PCLK_i) begin
        if (RESET_i) begin
            state_q    <= ST_UNLOCKED;
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
            pend_bad_q <= 1'b0;
            cfg_req_q  <= 1'b0;
            cfg_id_q   <= '0;
            out_en_q   <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_UNLOCKED: begin
                    if (frame_valid && frame_good) begin
                        if (good_cnt_q == LOCK_LAST) begin
                            cfg_id_q   <= mclk_cfg_id_i;
                            cfg_req_q  <= 1'b1;
                            pend_bad_q <= 1'b0;
                            good_cnt_q <= '0;
                            state_q    <= ST_CFG_REQ;
                        end else begin
                            good_cnt_q <= good_cnt_q + 8'd1;
                        end
                    end else if (frame_bad) begin
                        good_cnt_q <= '0;
                    end
                end
                ST_CFG_REQ: begin
                    // A bad verdict landing on the ack cycle still aborts the lock.
                    if (cfg_ack_i) begin
                        cfg_req_q <= 1'b0;
                        if (pend_bad_q || frame_bad) begin
                            good_cnt_q <= '0;
                            state_q    <= ST_UNLOCKED;
                        end else begin
                            bad_cnt_q <= '0;
                            out_en_q  <= 1'b1;
                            locked_q  <= 1'b1;
                            state_q   <= ST_LOCKED;
                        end
                    end else if (frame_bad) begin
                        pend_bad_q <= 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (frame_bad) begin
                        if (bad_cnt_q == UNLOCK_LAST) begin
                            bad_cnt_q  <= '0;
                            good_cnt_q <= '0;
                            out_en_q   <= 1'b0;
                            locked_q   <= 1'b0;
                            state_q    <= ST_UNLOCKED;
                        end else begin
                            bad_cnt_q <= bad_cnt_q + 8'd1;
                        end
                    end else if (frame_valid) begin
                        bad_cnt_q <= '0;
                    end
                end
                default: begin
                    good_cnt_q <= '0;
                    bad_cnt_q  <= '0;
                    cfg_req_q  <= 1'b0;
                    out_en_q   <= 1'b0;
                    locked_q   <= 1'b0;
                    state_q    <= ST_UNLOCKED;
                end
            endcase
        end
    end

    assign cfg_req_o = cfg_req_q;
    assign cfg_id_o  = cfg_id_q;
    assign out_en_o  = out_en_q;
    assign locked_o  = locked_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_cps1_sync_lock_ctrl.sv
// Scoreboarded bench: an event-timestamp reference model predicts every output
// change (with its cycle) and a negedge monitor matches DUT output changes.
module tb_cps1_sync_lock_ctrl;

    localparam int HN = 40, HT = 4, VN = 10, VT = 2, LF = 4, UF = 2, TO = 1500;

    logic        PCLK = 1'b0;
    logic        RESET_i = 1'b1, HSYNC_i = 1'b1, frame_change_i = 1'b0, cfg_ack_i = 1'b0;
    logic [4:0]  mclk_cfg_id_i = 5'd0;
    logic        cfg_req_o, out_en_o, locked_o;
    logic [4:0]  cfg_id_o;
    logic [1:0]  state_o;
    logic [10:0] line_pclks_o;
    logic [9:0]  frame_lines_o;

    cps1_sync_lock_ctrl #(
        .H_NOM(HN), .H_TOL(HT), .V_NOM(VN), .V_TOL(VT),
        .LOCK_FRAMES(LF), .UNLOCK_FRAMES(UF), .TIMEOUT(TO)
    ) dut (
        .PCLK_i(PCLK), .RESET_i(RESET_i), .HSYNC_i(HSYNC_i),
        .frame_change_i(frame_change_i), .mclk_cfg_id_i(mclk_cfg_id_i),
        .cfg_ack_i(cfg_ack_i), .cfg_req_o(cfg_req_o), .cfg_id_o(cfg_id_o),
        .out_en_o(out_en_o), .locked_o(locked_o), .state_o(state_o),
        .line_pclks_o(line_pclks_o), .frame_lines_o(frame_lines_o)
    );

    always #5 PCLK = ~PCLK;

    int checks = 0, errors = 0, cyc = 0;
    int ack_delay = 3, req_cnt = 0;
    bit stray_en = 1'b0;

    typedef struct { int cyc; logic [30:0] v; } rec_t;
    rec_t exp_q[$];

    function automatic logic [30:0] pack(input logic req, input logic [4:0] id, input logic en,
                                         input logic lk, input logic [1:0] st,
                                         input logic [10:0] lp, input logic [9:0] fl);
        return {req, id, en, lk, st, lp, fl};
    endfunction

    // Reference model: line/frame timing from event timestamps, lock rules as plain counters.
    int m_prev_hs, m_prev_fc, m_last_ev, m_last_bnd, m_lines, m_lerr;
    int m_v_valid, m_v_good, m_mode, m_gc, m_bc, m_pend, m_req, m_id, m_lp, m_fl;
    logic [30:0] m_last_v = '0;

    always @(posedge PCLK) begin
        int hs_ev, bnd, len, ok_line, nv_valid, nv_good;
        logic [30:0] v;
        cyc++;
        if (RESET_i) begin
            m_prev_hs = 0; m_prev_fc = 0; m_last_ev = cyc; m_last_bnd = cyc;
            m_lines = 0; m_lerr = 0; m_v_valid = 0; m_v_good = 0;
            m_mode = 0; m_gc = 0; m_bc = 0; m_pend = 0; m_req = 0; m_id = 0; m_lp = 0; m_fl = 0;
        end else begin
            hs_ev = (m_prev_hs != 0 && !HSYNC_i) ? 1 : 0;
            bnd   = (m_prev_fc == 0 && frame_change_i) ? 1 : 0;
            m_prev_hs = HSYNC_i ? 1 : 0;
            m_prev_fc = frame_change_i ? 1 : 0;
            case (m_mode)
                0: if (m_v_valid != 0) begin
                    if (m_v_good != 0) begin
                        if (m_gc == LF - 1) begin
                            m_id = int'(mclk_cfg_id_i); m_req = 1; m_mode = 1; m_pend = 0; m_gc = 0;
                        end else m_gc++;
                    end else m_gc = 0;
                end
                1: if (cfg_ack_i) begin
                    m_req = 0;
                    if (m_pend != 0 || (m_v_valid != 0 && m_v_good == 0)) begin m_mode = 0; m_gc = 0; end
                    else begin m_mode = 2; m_bc = 0; end
                end else if (m_v_valid != 0 && m_v_good == 0) m_pend = 1;
                default: if (m_v_valid != 0) begin
                    if (m_v_good == 0) begin
                        if (m_bc == UF - 1) begin m_mode = 0; m_gc = 0; m_bc = 0; end
                        else m_bc++;
                    end else m_bc = 0;
                end
            endcase
            ok_line = 1;
            if (hs_ev != 0) begin
                len = cyc - m_last_ev;
                if (len > 2047) len = 2047;
                m_lp = len; m_last_ev = cyc;
                ok_line = (len >= HN - HT && len <= HN + HT) ? 1 : 0;
            end
            nv_valid = 0; nv_good = 0;
            if (bnd != 0) begin
                nv_valid = 1;
                nv_good  = (m_lines >= VN - VT && m_lines <= VN + VT && m_lerr == 0 && ok_line != 0) ? 1 : 0;
                m_fl = m_lines; m_lines = hs_ev; m_lerr = 0; m_last_bnd = cyc;
            end else begin
                if (hs_ev != 0) begin
                    if (m_lines < 1023) m_lines++;
                    if (ok_line == 0) m_lerr = 1;
                end
                if (cyc - m_last_bnd == TO) begin nv_valid = 1; m_last_bnd = cyc; end
            end
            m_v_valid = nv_valid; m_v_good = nv_good;
        end
        v = pack(1'(m_req), 5'(m_id), m_mode == 2, m_mode == 2, 2'(m_mode), 11'(m_lp), 10'(m_fl));
        if (v !== m_last_v) exp_q.push_back('{cyc, v});
        m_last_v = v;
    end

    // Monitor: each DUT output change must match the next predicted change.
    logic [30:0] d_last = '0;
    always @(negedge PCLK) begin
        logic [30:0] dv;
        rec_t r;
        if (cyc > 0) begin
            dv = pack(cfg_req_o, cfg_id_o, out_en_o, locked_o, state_o, line_pclks_o, frame_lines_o);
            if (dv !== d_last) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_change cyc=%0d got=%h required=no change", cyc, dv);
                end else begin
                    r = exp_q.pop_front();
                    if (r.cyc != cyc || r.v !== dv) begin
                        errors++;
                        $display("FAIL out_change cyc=%0d got=%h required cyc=%0d val=%h", cyc, dv, r.cyc, r.v);
                    end
                end
                d_last = dv;
            end
        end
    end

    // MCLK ack responder, with optional stray acks outside the request window.
    always @(negedge PCLK) begin
        if (cfg_req_o === 1'b1) begin
            cfg_ack_i = (req_cnt >= ack_delay);
            req_cnt++;
        end else begin
            req_cnt = 0;
            cfg_ack_i = stray_en && ($urandom_range(39, 0) == 0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge PCLK);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got=%0h required=%0h", name, got, req);
        end
    endtask

    task automatic run_frame(input int nlines, input int lo, input int hi,
                             input int bad_idx, input int bad_len, input bit with_fc);
        int len;
        mclk_cfg_id_i = 5'($urandom);
        for (int i = 0; i < nlines; i++) begin
            len = (i == bad_idx) ? bad_len : int'($urandom_range(hi, lo));
            HSYNC_i = 1'b0;
            frame_change_i = with_fc && (i == 0);
            tick(4);
            HSYNC_i = 1'b1;
            frame_change_i = 1'b0;
            tick(len - 4);
        end
    endtask

    task automatic good(input int n);
        repeat (n) run_frame(VN, HN, HN, -1, 0, 1'b1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"}, 32'(cfg_req_o), 0);
        chk({tag, "_id"}, 32'(cfg_id_o), 0);
        chk({tag, "_en"}, 32'(out_en_o), 0);
        chk({tag, "_lock"}, 32'(locked_o), 0);
        chk({tag, "_state"}, 32'(state_o), 0);
        chk({tag, "_lp"}, 32'(line_pclks_o), 0);
        chk({tag, "_fl"}, 32'(frame_lines_o), 0);
    endtask

    initial begin
        tick(3);
        chk_all_zero("reset");
        RESET_i = 1'b0;
        tick(5);

        // Nominal lock
        good(7);
        chk("nom_locked", 32'(locked_o), 1);
        chk("nom_out_en", 32'(out_en_o), 1);
        chk("nom_state", 32'(state_o), 2);

        // Tolerance edges and isolated bad frames while locked
        run_frame(VN - VT, HN + HT, HN + HT, -1, 0, 1'b1);
        run_frame(VN + VT, HN - HT, HN - HT, -1, 0, 1'b1);
        run_frame(VN, HN, HN, 3, HN + HT + 1, 1'b1);
        good(1);
        run_frame(VN + VT + 1, HN, HN, -1, 0, 1'b1);
        good(1);
        chk("single_bad_locked", 32'(locked_o), 1);

        // Lock drop: one bad, good, then two consecutive bad
        run_frame(30, HN, HN, -1, 0, 1'b1);
        good(1);
        run_frame(30, HN, HN, -1, 0, 1'b1);
        run_frame(30, HN, HN, -1, 0, 1'b1);
        good(1);
        chk("drop_state", 32'(state_o), 0);
        chk("drop_out_en", 32'(out_en_o), 0);

        // Relock with a bad line restarting the count
        run_frame(VN - VT, HN + HT, HN + HT, -1, 0, 1'b1);
        run_frame(VN + VT, HN - HT, HN - HT, -1, 0, 1'b1);
        run_frame(VN, HN, HN, 2, HN - HT - 1, 1'b1);
        good(5);
        chk("relock", 32'(locked_o), 1);

        // Bad frame during a long-delayed ack
        run_frame(VN + VT + 1, HN, HN, -1, 0, 1'b1);
        run_frame(VN + VT + 1, HN, HN, -1, 0, 1'b1);
        ack_delay = 2 * VN * HN + 50;
        good(4);
        run_frame(VN, HN, HN, 3, HN + HT + 1, 1'b1);
        good(3);
        chk("pend_bad_locked", 32'(locked_o), 0);
        chk("pend_bad_state", 32'(state_o), 0);
        chk("pend_bad_req", 32'(cfg_req_o), 0);

        // Watchdog: relock, then frame_change stuck low
        ack_delay = 3;
        good(5);
        chk("wd_pre_locked", 32'(locked_o), 1);
        run_frame(2 * TO / HN + 5, HN, HN, -1, 0, 1'b0);
        chk("wd_state", 32'(state_o), 0);
        chk("wd_locked", 32'(locked_o), 0);

        // Reset pulse while the request is outstanding
        ack_delay = 100000;
        fork
            good(6);
            begin
                int k;
                for (k = 0; k < 4000 && cfg_req_o !== 1'b1; k++) tick(1);
                if (cfg_req_o !== 1'b1) begin
                    errors++;
                    $display("FAIL cfg_req_timeout got=%b required=1", cfg_req_o);
                end else begin
                    RESET_i = 1'b1;
                    tick(1);
                    chk_all_zero("midreset");
                    RESET_i = 1'b0;
                end
                ack_delay = 3;
            end
        join
        good(6);
        chk("post_reset_locked", 32'(locked_o), 1);

        // Randomised frames with stray acks
        stray_en = 1'b1;
        for (int f = 0; f < 30; f++) begin
            int t;
            t = int'($urandom_range(5, 0));
            ack_delay = int'($urandom_range(20, 0));
            case (t)
                4: run_frame(($urandom_range(1, 0) != 0) ? VN + VT + 1 : VN - VT - 1,
                             HN - HT, HN + HT, -1, 0, 1'b1);
                5: run_frame(VN, HN - HT, HN + HT, int'($urandom_range(VN - 1, 0)),
                             ($urandom_range(1, 0) != 0) ? HN + HT + 1 : HN - HT - 1, 1'b1);
                default: run_frame(int'($urandom_range(VN + VT, VN - VT)), HN - HT, HN + HT, -1, 0, 1'b1);
            endcase
        end
        stray_en = 1'b0;
        good(1);
        tick(20);
        chk("queue_drained", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
